result_sram_ctrl: RTL and testbench
===================================

Name: result_sram_ctrl

Overview:
Front-end controller for the 128x32 result SRAM.
- Accepts a stream of 32-bit results on a valid/ready interface and writes them to consecutive SRAM addresses starting at 0.
- On a Dump request, reads back every stored word in address order and presents each one on a valid/ready output stream.
- After the last word is accepted, the buffer is treated as empty.
- Drives the SRAM Addr/RW/En/Data_In pins and consumes its registered Data_Out, which has one-cycle read latency and reads as zero when no read is active.

Parameters:
A_WIDTH, 7, SRAM address width (depth 2**A_WIDTH = 128)
D_WIDTH, 32, data word width

Ports:
Clk  in  1  clock, all logic on posedge
Rst  in  1  synchronous, active-high reset; shared with the SRAM
In_Valid  in  1  result word present
In_Data  in  D_WIDTH  result word
In_Ready  out  1  controller can accept a word this cycle
Dump  in  1  request readout of all stored words (level sampled in IDLE)
Out_Valid  out  1  Out_Data valid
Out_Data  out  D_WIDTH  readout word
Out_Ready  in  1  downstream accepts Out_Data
Done  out  1  one-cycle pulse when a dump completes
Count  out  A_WIDTH+1  number of stored words, 0..128
Full  out  1  Count == 128
Sram_Addr  out  A_WIDTH  to SRAM Addr
Sram_RW  out  1  to SRAM RW (1 = write, 0 = read)
Sram_En  out  1  to SRAM En
Sram_Din  out  D_WIDTH  to SRAM Data_In
Sram_Dout  in  D_WIDTH  from SRAM Data_Out

Behaviour:
- Reset, when Rst=1 at a posedge:
  - state = IDLE; Count, rd_ptr, Out_Data, Out_Valid and Done all return to 0.
  - Reset overrides every other input, including mid-dump; no further Out_Valid is produced after an aborted dump.
- States: IDLE, RD, WAIT, OUT, FIN.
- Write path (IDLE only):
  - In_Ready = (state==IDLE) && !Full, combinational.
  - On In_Valid && In_Ready: Sram_En=1, Sram_RW=1, Sram_Addr=Count[A_WIDTH-1:0], Sram_Din=In_Data, all combinational in that cycle; Count increments at the edge.
  - Full is combinational from Count. At Count=128, In_Valid is ignored and no SRAM access is made.
- Idle SRAM drive: whenever no access is being made, Sram_En=0, Sram_RW=0, Sram_Addr=0, Sram_Din=0.
- Dump entry:
  - Dump=1 in IDLE with Count>0: go to RD at the next edge with rd_ptr=0.
  - Dump=1 in IDLE with Count==0: go to FIN.
  - Simultaneous In_Valid && In_Ready and Dump in IDLE: the write is performed and the new word is included in the dump.
  - Dump is ignored outside IDLE.
- RD (1 cycle): Sram_En=1, Sram_RW=0, Sram_Addr=rd_ptr. Next state WAIT.
- WAIT (1 cycle): Sram_Dout holds Memory[rd_ptr]. At the edge, Out_Data <= Sram_Dout, Out_Valid <= 1, next state OUT.
- Latency: Dump sampled at edge N gives Out_Valid=1 after edge N+2. Throughput is 1 word per 3 cycles when Out_Ready is held high.
- OUT:
  - Out_Valid=1. Out_Data is held stable while Out_Ready=0; no SRAM access is made.
  - On Out_Ready=1 at the edge: Out_Valid <= 0.
  - If rd_ptr == Count-1, go to FIN. Otherwise rd_ptr increments and the state returns to RD.
- FIN (1 cycle):
  - Done=1, registered, high for exactly one cycle.
  - At the edge: Count <= 0, rd_ptr <= 0, state = IDLE.
  - In_Ready=0 during FIN.
- SRAM contents are not cleared by a dump; stale data is overwritten on the next fill.
- Width rules:
  - Count is A_WIDTH+1 bits so that 128 is representable; it never exceeds 128.
  - rd_ptr is A_WIDTH bits; Count-1 is compared at A_WIDTH+1 bits.

Test Plan:
1. Rst, then write 0xA, 0xB, 0xC back-to-back with Out_Ready=1, then Dump=1 for 1 cycle -> SRAM writes at addresses 0,1,2; Out_Data 0xA, 0xB, 0xC each with a 1-cycle Out_Valid, 3 cycles apart; first Out_Valid 2 edges after Dump; Done pulse; Count=0.
2. Write 128 words of value 0x1000+i -> Full=1 and In_Ready=0 after the 128th; a 129th In_Valid causes no SRAM access and Count stays 128; dump returns 0x1000..0x107F in order.
3. Two words stored, Dump, Out_Ready=0 for 5 cycles on the first word -> Out_Valid held high, Out_Data stable, Sram_En=0; on release, second word follows.
4. Dump with Count=0 -> Done=1 one cycle later, Out_Valid never asserted, back in IDLE with In_Ready=1.
5. Four words stored, Dump, Rst asserted after the second word is accepted -> next cycle Out_Valid=0, Count=0, Done=0, In_Ready=1, no further reads.
6. Count=2, In_Valid with 0x55 and Dump in the same cycle -> write to address 2 occurs, dump outputs 3 words ending in 0x55.

Source files
------------

// File: rtl/result_sram_ctrl.sv
// Result SRAM front end: fills the 128x32 SRAM from an input stream
// and dumps it back out in address order on request.
module result_sram_ctrl #(
   parameter int A_WIDTH = 7,
   parameter int D_WIDTH = 32
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               In_Valid,
   input  logic [D_WIDTH-1:0] In_Data,
   output logic               In_Ready,
   input  logic               Dump,
   output logic               Out_Valid,
   output logic [D_WIDTH-1:0] Out_Data,
   input  logic               Out_Ready,
   output logic               Done,
   output logic [A_WIDTH:0]   Count,
   output logic               Full,
   output logic [A_WIDTH-1:0] Sram_Addr,
   output logic               Sram_RW,
   output logic               Sram_En,
   output logic [D_WIDTH-1:0] Sram_Din,
   input  logic [D_WIDTH-1:0] Sram_Dout
);

   localparam int unsigned DEPTH_I = 1 << A_WIDTH;
   localparam logic [A_WIDTH:0] DEPTH = DEPTH_I[A_WIDTH:0];
   localparam logic [A_WIDTH:0] ONE = {{A_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WAIT,
      OUT,
      FIN
   } state_t;

   state_t               state_q, state_d;
   logic [A_WIDTH:0]     count_q, count_d;
   logic [A_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [D_WIDTH-1:0]   out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic                 wr;
   logic                 last;

   assign Full      = (count_q == DEPTH);
   assign In_Ready  = (state_q == IDLE) && !Full;
   assign wr        = In_Valid && In_Ready;
   assign last      = ({1'b0, rd_ptr_q} == (count_q - ONE));
   assign Count     = count_q;
   assign Out_Valid = out_valid_q;
   assign Out_Data  = out_data_q;
   assign Done      = (state_q == FIN);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      Sram_En     = 1'b0;
      Sram_RW     = 1'b0;
      Sram_Addr   = '0;
      Sram_Din    = '0;
      unique case (state_q)
         IDLE: begin
            if (wr) begin
               Sram_En   = 1'b1;
               Sram_RW   = 1'b1;
               Sram_Addr = count_q[A_WIDTH-1:0];
               Sram_Din  = In_Data;
               count_d   = count_q + ONE;
            end
            // a word written alongside Dump is part of the dump
            if (Dump) begin
               rd_ptr_d = '0;
               state_d  = (count_d != '0) ? RD : FIN;
            end
         end
         RD: begin
            Sram_En   = 1'b1;
            Sram_Addr = rd_ptr_q;
            state_d   = WAIT;
         end
         WAIT: begin
            out_data_d  = Sram_Dout;
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (Out_Ready) begin
               out_valid_d = 1'b0;
               if (last) begin
                  state_d = FIN;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
                  state_d  = RD;
               end
            end
         end
         FIN: begin
            count_d  = '0;
            rd_ptr_d = '0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_result_sram_ctrl.sv
// Bench for result_sram_ctrl: SRAM model, a stored-word queue model
// checked every cycle, and directed scenarios with literal expectations.
module tb_result_sram_ctrl;

   localparam int AW = 7;
   localparam int DW = 32;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          In_Valid;
   logic [DW-1:0] In_Data;
   logic          In_Ready;
   logic          Dump;
   logic          Out_Valid;
   logic [DW-1:0] Out_Data;
   logic          Out_Ready;
   logic          Done;
   logic [AW:0]   Count;
   logic          Full;
   logic [AW-1:0] Sram_Addr;
   logic          Sram_RW;
   logic          Sram_En;
   logic [DW-1:0] Sram_Din;
   logic [DW-1:0] Sram_Dout;

   result_sram_ctrl #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
      .Clk(Clk), .Rst(Rst),
      .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(In_Ready),
      .Dump(Dump),
      .Out_Valid(Out_Valid), .Out_Data(Out_Data), .Out_Ready(Out_Ready),
      .Done(Done), .Count(Count), .Full(Full),
      .Sram_Addr(Sram_Addr), .Sram_RW(Sram_RW), .Sram_En(Sram_En),
      .Sram_Din(Sram_Din), .Sram_Dout(Sram_Dout)
   );

   always #5 Clk = ~Clk;

   // SRAM: registered read data, zero when no read is active
   logic [DW-1:0] mem [128];
   always @(posedge Clk) begin
      if (Rst) begin
         Sram_Dout <= '0;
      end else begin
         if (Sram_En && !Sram_RW) Sram_Dout <= mem[Sram_Addr];
         else Sram_Dout <= '0;
         if (Sram_En && Sram_RW) mem[Sram_Addr] <= Sram_Din;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // model: words stored so far, and how many have been handed out
   logic [DW-1:0] st [$];
   logic [DW-1:0] seen [$];
   int            rd_idx = 0;
   logic          prev_hold = 1'b0;
   logic [DW-1:0] prev_data = '0;

   always @(negedge Clk) begin
      if (Rst) begin
         st.delete();
         rd_idx    = 0;
         prev_hold = 1'b0;
      end else begin
         chk("count", Count, st.size());
         chk("full", Full, st.size() == 128);
         if (!Sram_En) chk("idle_drive", {Sram_RW, Sram_Addr, Sram_Din}, 0);
         if (prev_hold) chk("hold", {Out_Valid, Out_Data}, {1'b1, prev_data});
         if (In_Valid && In_Ready) begin
            chk("wr_en", {Sram_En, Sram_RW}, 2'b11);
            chk("wr_addr", Sram_Addr, st.size());
            chk("wr_data", Sram_Din, In_Data);
         end
         if (Out_Valid && Out_Ready) begin
            if (rd_idx < st.size()) chk("out_data", Out_Data, st[rd_idx]);
            else chk("out_extra", rd_idx, st.size());
            seen.push_back(Out_Data);
            rd_idx++;
         end
         if (Done) begin
            chk("done_all", rd_idx, st.size());
            st.delete();
            rd_idx = 0;
         end
         if (In_Valid && In_Ready) st.push_back(In_Data);
         prev_hold = Out_Valid && !Out_Ready;
         prev_data = Out_Data;
      end
   end

   task automatic wr_word(input logic [DW-1:0] d);
      In_Valid = 1'b1;
      In_Data  = d;
      @(posedge Clk); #1;
      In_Valid = 1'b0;
   endtask

   task automatic dump_pulse();
      Dump = 1'b1;
      @(posedge Clk); #1;
      Dump = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int bound);
      logic found;
      found = 1'b0;
      for (int i = 0; i < bound && !found; i++) begin
         @(negedge Clk);
         if (Done) found = 1'b1;
      end
      chk(nm, found, 1'b1);
      @(posedge Clk); #1;
   endtask

   initial begin
      logic [15:0] ov, dn;
      logic        got;
      Rst = 1'b1; In_Valid = 1'b0; In_Data = '0;
      Dump = 1'b0; Out_Ready = 1'b1;
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      chk("rst_state", {Count, Out_Valid, Done, In_Ready, Full}, 12'h002);
      chk("rst_data", Out_Data, 0);

      // 1: three words, dump, timing pattern
      seen.delete();
      wr_word(32'hA); wr_word(32'hB); wr_word(32'hC);
      dump_pulse();
      ov = '0; dn = '0;
      for (int k = 1; k <= 11; k++) begin
         @(negedge Clk);
         ov[k] = Out_Valid;
         dn[k] = Done;
      end
      chk("t1_valid_pattern", ov, 16'h0248);
      chk("t1_done_pattern", dn, 16'h0400);
      chk("t1_words", seen.size(), 3);
      if (seen.size() == 3) chk("t1_data", {seen[0], seen[1], seen[2]},
                                {32'hA, 32'hB, 32'hC});
      chk("t1_count", Count, 0);
      @(posedge Clk); #1;

      // 2: fill to 128, overflow attempt, full dump
      seen.delete();
      for (int i = 0; i < 128; i++) wr_word(32'h1000 + i);
      chk("t2_full", {Full, In_Ready, Count}, {2'b10, 8'd128});
      In_Valid = 1'b1; In_Data = 32'hDEAD;
      @(negedge Clk);
      chk("t2_no_access", Sram_En, 1'b0);
      @(posedge Clk); #1;
      In_Valid = 1'b0;
      chk("t2_count_held", Count, 128);
      dump_pulse();
      wait_done("t2_done_seen", 1000);
      chk("t2_words", seen.size(), 128);
      if (seen.size() == 128) begin
         chk("t2_first", seen[0], 32'h1000);
         chk("t2_mid", seen[64], 32'h1040);
         chk("t2_last", seen[127], 32'h107F);
      end

      // 4: dump of an empty buffer
      dump_pulse();
      @(negedge Clk);
      chk("t4_fin", {Done, Out_Valid}, 2'b10);
      @(negedge Clk);
      chk("t4_idle", {Done, Out_Valid, In_Ready}, 3'b001);
      @(posedge Clk); #1;

      // 3: backpressure on the first word
      seen.delete();
      wr_word(32'h11); wr_word(32'h22);
      Out_Ready = 1'b0;
      dump_pulse();
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         if (Out_Valid) got = 1'b1;
         else begin @(posedge Clk); #1; end
      end
      chk("t3_valid_seen", got, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         chk("t3_stall", {Out_Valid, Sram_En, Out_Data}, {2'b10, 32'h11});
      end
      @(posedge Clk); #1;
      Out_Ready = 1'b1;
      wait_done("t3_done_seen", 50);
      chk("t3_words", seen.size(), 2);
      if (seen.size() == 2) chk("t3_data", {seen[0], seen[1]},
                                {32'h11, 32'h22});

      // 5: reset in the middle of a dump
      seen.delete();
      for (int i = 0; i < 4; i++) wr_word(32'h70 + i);
      dump_pulse();
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge Clk);
         if (seen.size() >= 2) got = 1'b1;
      end
      chk("t5_two_seen", got, 1'b1);
      @(posedge Clk); #1 Rst = 1'b1;
      @(posedge Clk); #1 Rst = 1'b0;
      @(negedge Clk);
      chk("t5_after_rst", {Out_Valid, Count, Done, In_Ready},
          {1'b0, 8'd0, 1'b0, 1'b1});
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         chk("t5_quiet", {Sram_En, Out_Valid}, 2'b00);
      end
      chk("t5_words", seen.size(), 2);
      @(posedge Clk); #1;

      // 6: write and dump in the same cycle
      seen.delete();
      wr_word(32'h01); wr_word(32'h02);
      In_Valid = 1'b1; In_Data = 32'h55; Dump = 1'b1;
      @(negedge Clk);
      chk("t6_write", {Sram_En, Sram_RW, Sram_Addr}, {2'b11, 7'd2});
      @(posedge Clk); #1;
      In_Valid = 1'b0; Dump = 1'b0;
      wait_done("t6_done_seen", 50);
      chk("t6_words", seen.size(), 3);
      if (seen.size() == 3) chk("t6_data", {seen[0], seen[1], seen[2]},
                                {32'h01, 32'h02, 32'h55});

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
